intctl: RTL

//  Interrupt controller feeding the CPU datapath PC path and the control unit.

---
 rtl/intctl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/intctl.sv
// Interrupt controller: synchronises and edge-detects IRQ lines, keeps them
// pending, and hands the highest-priority unmasked line to the control unit.
module intctl #(
  parameter int unsigned     NIRQ       = 4,
  parameter int unsigned     AW         = 10,
  parameter logic [AW-1:0]   VEC_BASE   = 10'h3C0,
  parameter int unsigned     VEC_STRIDE = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq,
  input  logic            int_en,
  input  logic            we_mask,
  input  logic [NIRQ-1:0] mask_in,
  input  logic            int_ack,
  input  logic            reti,
  output logic            int_req,
  output logic [AW-1:0]   vector,
  output logic [NIRQ-1:0] in_service
);

  localparam int unsigned     IW  = (NIRQ > 1) ? $clog2(NIRQ) : 1;
  localparam logic [NIRQ-1:0] ONE = NIRQ'(1);

  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

  state_t          state;
  logic [NIRQ-1:0] s1;
  logic [NIRQ-1:0] s2;
  logic [NIRQ-1:0] prev;
  logic [NIRQ-1:0] armed;
  logic [NIRQ-1:0] edge_det;
  logic [NIRQ-1:0] pending;
  logic [NIRQ-1:0] mask;
  logic [NIRQ-1:0] cand;
  logic [NIRQ-1:0] ack_clr;
  logic [1:0]      fill;
  logic            sync_ok;
  logic            found;
  logic [IW-1:0]   sel;
  logic [IW-1:0]   idx;
  logic [AW-1:0]   sel_vec;

  // A line only arms once its synchronised level has been seen low after
  // reset, so a line already held high at reset release raises no event.
  assign sync_ok = (fill == 2'd2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1    <= '0;
      s2    <= '0;
      prev  <= '0;
      armed <= '0;
      fill  <= '0;
    end else begin
      s1    <= irq;
      s2    <= s1;
      prev  <= s2;
      armed <= armed | ({NIRQ{sync_ok}} & ~s2);
      if (!sync_ok) fill <= fill + 2'd1;
    end
  end

  assign edge_det = s2 & ~prev & armed;
  assign ack_clr  = (state == REQ && int_ack) ? (ONE << idx) : '0;

  // Set has priority over the acknowledge clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      mask    <= '0;
    end else begin
      pending <= (pending & ~ack_clr) | edge_det;
      if (we_mask) mask <= mask_in;
    end
  end

  assign cand = pending & ~mask;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NIRQ; i++) begin
      if (cand[i] && !found) begin
        sel   = IW'(i);
        found = 1'b1;
      end
    end
  end

  assign sel_vec = VEC_BASE + AW'(VEC_STRIDE * 32'(sel));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      int_req    <= 1'b0;
      vector     <= '0;
      idx        <= '0;
      in_service <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (int_en && found) begin
            state   <= REQ;
            int_req <= 1'b1;
            vector  <= sel_vec;
            idx     <= sel;
          end
        end
        REQ: begin
          if (int_ack) begin
            state      <= SERV;
            int_req    <= 1'b0;
            vector     <= '0;
            in_service <= ONE << idx;
          end else if (!int_en) begin
            state   <= IDLE;
            int_req <= 1'b0;
            vector  <= '0;
          end
        end
        SERV: begin
          if (reti) begin
            state      <= IDLE;
            in_service <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
